// File: rtl/sha256_round_ctrl_pkg.sv
// ============================================================================
//  Module   : sha256_round_ctrl_pkg
//  Purpose  : Shared definitions for the SHA-256 round controller: FSM state
//             encodings, initial hash value (IV), round constant table K and
//             the combinational SHA-256 round functions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_round_ctrl_pkg;

   typedef logic [31:0] word_t;

   // Controller state encodings
   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_round  = 2'd1;
   localparam logic [1:0] c_st_update = 2'd2;

   // Initial hash value H0..H7
   localparam word_t c_iv [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Round constants K[0..63]
   localparam word_t c_k [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t k_const(input logic [5:0] t);
      return c_k[t];
   endfunction

   function automatic word_t right_cyclic_shift(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Message schedule sigmas
   function automatic word_t func_sigma0(input word_t x);
      return right_cyclic_shift(x, 7) ^ right_cyclic_shift(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t func_sigma1(input word_t x);
      return right_cyclic_shift(x, 17) ^ right_cyclic_shift(x, 19) ^ (x >> 10);
   endfunction

   // Compression-round sums
   function automatic word_t func_bsigma0(input word_t x);
      return right_cyclic_shift(x, 2) ^ right_cyclic_shift(x, 13) ^ right_cyclic_shift(x, 22);
   endfunction

   function automatic word_t func_bsigma1(input word_t x);
      return right_cyclic_shift(x, 6) ^ right_cyclic_shift(x, 11) ^ right_cyclic_shift(x, 25);
   endfunction

   function automatic word_t func_ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t func_maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_msg_sched.sv
// ============================================================================
//  Module   : sha256_msg_sched
//  Purpose  : SHA-256 message schedule as a 16-word shift window. The window
//             always holds W[t..t+15], so the current word is simply entry 0
//             and each shift appends W[t+16] at the top.
//  Ports    : clk   - clock
//             load  - capture a new 512-bit block (W0 = data[511:480])
//             shift - advance the window by one word (one round)
//             data  - block input
//             wt    - W_t for the current round
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_sched
   import sha256_round_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         load,
   input  logic         shift,
   input  logic [511:0] data,
   output logic [31:0]  wt
);

   word_t r_win [16];
   word_t w_next;

   // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
   assign w_next = func_sigma1(r_win[14]) + r_win[9] + func_sigma0(r_win[1]) + r_win[0];

   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 16; i++) begin
            r_win[i] <= data[511 - 32*i -: 32];
         end
      end else if (shift) begin
         for (int i = 0; i < 15; i++) begin
            r_win[i] <= r_win[i+1];
         end
         r_win[15] <= w_next;
      end
   end

   assign wt = r_win[0];

endmodule

`default_nettype wire

// File: rtl/sha256_round_ctrl.sv
// ============================================================================
//  Module   : sha256_round_ctrl
//  Purpose  : Sequences one SHA-256 compression per accepted 512-bit block,
//             one round per clock. Owns chaining value H0..H7, working
//             variables a..h, the round counter and the K_t lookup.
//  Ports    : clk, rst_n (sync, active low)
//             blk_valid/blk_ready/blk_data/blk_first - block input handshake
//             busy         - high while compressing or updating H
//             digest_valid - one-cycle pulse when digest holds the new H
//             digest       - H0..H7, H0 in [255:224]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round_ctrl
   import sha256_round_ctrl_pkg::*;
#(
   parameter int ROUNDS = 64
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   output logic         busy,
   output logic         digest_valid,
   output logic [255:0] digest
);

   localparam logic [5:0] c_last_round = 6'(ROUNDS - 1);

   logic [1:0] r_state;
   logic [5:0] r_t;
   logic       r_digest_valid;
   word_t      r_hv [8];     // chaining value H0..H7
   word_t      r_wv [8];     // working variables a..h (index 0 = a)

   logic       w_accept;
   logic       w_in_round;
   word_t      w_wt;
   word_t      w_t1;
   word_t      w_t2;

   assign w_accept   = blk_valid && (r_state == c_st_idle);
   assign w_in_round = (r_state == c_st_round);

   sha256_msg_sched u_msg_sched (
      .clk   (clk),
      .load  (w_accept),
      .shift (w_in_round),
      .data  (blk_data),
      .wt    (w_wt)
   );

   // Round datapath
   assign w_t1 = r_wv[7] + func_bsigma1(r_wv[4]) + func_ch(r_wv[4], r_wv[5], r_wv[6])
               + k_const(r_t) + w_wt;
   assign w_t2 = func_bsigma0(r_wv[0]) + func_maj(r_wv[0], r_wv[1], r_wv[2]);

   // Control, chaining value and digest pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= c_st_idle;
         r_t            <= 6'd0;
         r_digest_valid <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_hv[i] <= c_iv[i];
         end
      end else begin
         r_digest_valid <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (blk_valid) begin
                  if (blk_first) begin
                     for (int i = 0; i < 8; i++) begin
                        r_hv[i] <= c_iv[i];
                     end
                  end
                  r_t     <= 6'd0;
                  r_state <= c_st_round;
               end
            end
            c_st_round: begin
               // Hold t at the last round rather than wrapping to 0
               if (r_t == c_last_round) begin
                  r_state <= c_st_update;
               end else begin
                  r_t <= r_t + 6'd1;
               end
            end
            c_st_update: begin
               for (int i = 0; i < 8; i++) begin
                  r_hv[i] <= r_hv[i] + r_wv[i];
               end
               r_digest_valid <= 1'b1;
               r_state        <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // Working variables are pure datapath; reset is irrelevant because they are
   // always reloaded on accept before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < 8; i++) begin
            r_wv[i] <= blk_first ? c_iv[i] : r_hv[i];
         end
      end else if (w_in_round) begin
         r_wv[7] <= r_wv[6];
         r_wv[6] <= r_wv[5];
         r_wv[5] <= r_wv[4];
         r_wv[4] <= r_wv[3] + w_t1;
         r_wv[3] <= r_wv[2];
         r_wv[2] <= r_wv[1];
         r_wv[1] <= r_wv[0];
         r_wv[0] <= w_t1 + w_t2;
      end
   end

   assign blk_ready    = (r_state == c_st_idle);
   assign busy         = (r_state == c_st_round) || (r_state == c_st_update);
   assign digest_valid = r_digest_valid;

   for (genvar gi = 0; gi < 8; gi++) begin : g_digest
      assign digest[255 - 32*gi -: 32] = r_hv[gi];
   end

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
// ============================================================================
//  Module   : tb_sha256_round_ctrl
//  Purpose  : Self-checking bench for sha256_round_ctrl. Expected digests come
//             from known SHA-256 vectors or from a behavioural compression
//             model; a monitor compares every digest_valid pulse against the
//             scoreboard queue, including accept-to-digest latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         blk_first = 1'b0;
   logic         busy;
   logic         digest_valid;
   logic [255:0] digest;

   sha256_round_ctrl #(.ROUNDS(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .busy         (busy),
      .digest_valid (digest_valid),
      .digest       (digest)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [255:0] IV_HASH = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_HASH = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_HASH = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_HASH = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

   logic [31:0] kt [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef struct {
      logic [255:0] dig;
      int           acc;
      string        name;
   } exp_t;

   exp_t         sb[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [255:0] model_h = IV_HASH;

   // ---------------- behavioural SHA-256 compression ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] xx;
      xx = {x, x} >> n;
      return xx[31:0];
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] s0, s1, t1, t2;
      logic [255:0] hout;
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return hout;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, got, req);
      end
   endtask

   // Present a block, wait (bounded) for acceptance, push expected digest.
   task automatic send(input logic [511:0] d, input logic f, input logic has_exp,
                       input logic [255:0] e, input string nm, output int acc);
      exp_t x;
      int   waitc;
      acc       = -1;
      blk_data  = d;
      blk_first = f;
      blk_valid = 1'b1;
      waitc     = 0;
      @(negedge clk);
      while (!blk_ready && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      if (!blk_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_accept: blk_ready stayed %b, required 1", nm, blk_ready);
         blk_valid = 1'b0;
         return;
      end
      if (f) model_h = IV_HASH;
      model_h = compress(model_h, d);
      x.dig  = has_exp ? e : model_h;
      x.acc  = cyc + 1;
      x.name = nm;
      acc    = x.acc;
      sb.push_back(x);
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (rst_n && digest_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_digest_valid: got pulse with digest %h, required no pulse", digest);
            end else begin
               x = sb.pop_front();
               if (digest !== x.dig) begin
                  n_fail++;
                  $display("FAIL %s_digest: got %h, required %h", x.name, digest, x.dig);
               end
               n_tests++;
               if (cyc != x.acc + 65) begin
                  n_fail++;
                  $display("FAIL %s_latency: got %0d, required %0d", x.name, cyc - x.acc, 65);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int           a1, a2, dummy, gap, waitc;
      logic [511:0] rnd;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_blk_ready", 256'(blk_ready), 256'(1'b1));
      chk("reset_busy", 256'(busy), 256'(1'b0));
      chk("reset_digest_valid", 256'(digest_valid), 256'(1'b0));
      chk("reset_digest", digest, IV_HASH);
      @(posedge clk); #1;

      // 1, 2: single-block known vectors
      send(ABC_BLK, 1'b1, 1'b1, ABC_HASH, "abc", dummy);
      send(EMPTY_BLK, 1'b1, 1'b1, EMPTY_HASH, "empty", dummy);

      // 3: two-block message, second block waiting during the first compression
      send(TWO_BLK1, 1'b1, 1'b0, '0, "two_blk1", a1);
      send(TWO_BLK2, 1'b0, 1'b1, TWO_HASH, "two_blk2", a2);
      chk("b2b_accept_in_digest_cycle", 256'(a2 - a1), 256'(66));

      // 4: garbage held on the input while busy must not be accepted
      send(ABC_BLK, 1'b1, 1'b1, ABC_HASH, "abc_garbage", dummy);
      for (int i = 0; i < 60; i++) begin
         blk_valid = 1'b1;
         for (int j = 0; j < 16; j++) blk_data[32*j +: 32] = $urandom;
         blk_first = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("busy_blk_ready", 256'({blk_ready, busy}), 256'(2'b01));
         @(posedge clk); #1;
      end
      blk_valid = 1'b0;

      // 5: reset mid-compression abandons the block
      send(ABC_BLK, 1'b1, 1'b1, ABC_HASH, "abc_abandon", dummy);
      repeat (30) @(posedge clk);
      #1;
      void'(sb.pop_back());
      model_h = IV_HASH;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_digest", digest, IV_HASH);
      chk("midreset_ready_busy", 256'({blk_ready, busy}), 256'(2'b10));
      repeat (70) @(posedge clk);
      #1;
      send(ABC_BLK, 1'b1, 1'b1, ABC_HASH, "abc_after_reset", dummy);

      // 6: two consecutive first-blocks give identical digests
      send(ABC_BLK, 1'b1, 1'b1, ABC_HASH, "abc_rep1", dummy);
      send(ABC_BLK, 1'b1, 1'b1, ABC_HASH, "abc_rep2", dummy);

      // Random blocks, random message starts, random idle gaps
      for (int n = 0; n < 12; n++) begin
         for (int j = 0; j < 16; j++) rnd[32*j +: 32] = $urandom;
         send(rnd, (n == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, '0, $sformatf("rand%0d", n), dummy);
         gap = $urandom_range(0, 70);
         repeat (gap) @(posedge clk);
         #1;
      end

      // Drain the scoreboard (bounded)
      waitc = 0;
      while (sb.size() != 0 && waitc < 300) begin
         @(posedge clk);
         waitc++;
      end
      chk("scoreboard_drained", 256'(sb.size()), 256'(0));
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
